digit_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller feeding the 3-to-8 digit-enable decoder.

---
 rtl/digit_scan_ctrl_pkg.sv | 19 +
 rtl/digit_scan_ctrl_next_enabled_idx.sv | 35 +++
 rtl/digit_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_digit_scan_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/digit_scan_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scan_pkg : shared types and sizes for the digit scan controller      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int NDIG  = 8;
  localparam int SEL_W = 3;
  localparam int NIB_W = 4;

endpackage
`default_nettype wire

// File: rtl/digit_scan_ctrl_next_enabled_idx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | next_enabled_idx : circular priority finder over the digit mask      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module next_enabled_idx
  import scan_pkg::*;
(
  input  logic [NDIG-1:0]  mask,
  input  logic [SEL_W-1:0] start,
  input  logic             inclusive,
  output logic [SEL_W-1:0] idx,
  output logic             found,
  output logic             wrapped
);

  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] cand;

  // Walk from the far end back toward base so the nearest hit wins.
  always_comb begin
    base = start + (inclusive ? 3'd0 : 3'd1);
    idx  = '0;
    cand = '0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      cand = base + SEL_W'(k);
      if (mask[cand]) idx = cand;
    end
  end

  assign found   = |mask;
  assign wrapped = inclusive ? (idx < start) : (idx <= start);

endmodule
`default_nettype wire

// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | digit_scan_ctrl : dwell/blank scan sequencer for a 3-to-8 decoder    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int SHOW_CYC  = 1000,
  parameter int BLANK_CYC = 50,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [NDIG-1:0]  digit_mask,
  input  logic [31:0]      data,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic [NIB_W-1:0] nibble,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SEL_W-1:0] sel_q;
  logic             en_q;
  logic [NIB_W-1:0] nibble_q;
  logic             frame_done_q;

  logic [SEL_W-1:0] sel_d;
  logic [NIB_W-1:0] nibble_d;
  logic             found_d;
  logic             wrap_d;
  logic             adv_d;

  // IDLE exit resumes on the current digit; an advance starts past it.
  next_enabled_idx u_find (
    .mask      (digit_mask),
    .start     (sel_q),
    .inclusive (state_q == IDLE),
    .idx       (sel_d),
    .found     (found_d),
    .wrapped   (wrap_d)
  );

  assign nibble_d = data[{sel_d, 2'b00} +: NIB_W];

  assign adv_d = ((state_q == SHOW) && (cnt_q == SHOW_LAST) && (BLANK_CYC == 0)) ||
                 ((state_q == BLANK) && (cnt_q == BLANK_LAST));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      en_q         <= 1'b0;
      nibble_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if ((state_q != IDLE) && !run) begin
        state_q <= IDLE;
        en_q    <= 1'b0;
        cnt_q   <= '0;
      end else if (adv_d) begin
        cnt_q <= '0;
        if (found_d) begin
          state_q      <= SHOW;
          sel_q        <= sel_d;
          nibble_q     <= nibble_d;
          en_q         <= 1'b1;
          frame_done_q <= wrap_d;
        end else begin
          state_q <= IDLE;
          en_q    <= 1'b0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            en_q  <= 1'b0;
            cnt_q <= '0;
            if (run && found_d) begin
              state_q  <= SHOW;
              sel_q    <= sel_d;
              nibble_q <= nibble_d;
              en_q     <= 1'b1;
            end
          end
          SHOW: begin
            if (cnt_q == SHOW_LAST) begin
              state_q <= BLANK;
              en_q    <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          BLANK: begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          default: begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign sel        = sel_q;
  assign en         = en_q;
  assign nibble     = nibble_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_digit_scan_ctrl : scoreboard bench for digit_scan_ctrl            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_digit_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, run, run0;
  logic [7:0]  mask, mask0;
  logic [31:0] data;
  logic [2:0]  sel, sel0;
  logic        en, en0, fd, fd0;
  logic [3:0]  nib, nib0;

  always #5 clk = ~clk;

  digit_scan_ctrl #(.SHOW_CYC(4), .BLANK_CYC(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .digit_mask(mask), .data(data),
    .sel(sel), .en(en), .nibble(nib), .frame_done(fd)
  );

  digit_scan_ctrl #(.SHOW_CYC(4), .BLANK_CYC(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .run(run0), .digit_mask(mask0), .data(data),
    .sel(sel0), .en(en0), .nibble(nib0), .frame_done(fd0)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] nib;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // With data = 0x76543210 each digit shows its own index as the nibble.
  task automatic push(input logic [2:0] s, input logic f);
    exp_t e;
    e.sel = s;
    e.nib = {1'b0, s};
    e.fd  = f;
    sb.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_show(input logic [2:0] s, input int maxc, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(en === 1'b1 && sel === s) && n < maxc);
    chk(tag, {63'd0, (en === 1'b1 && sel === s)}, 64'd1);
  endtask

  // A new digit starts when en rises or sel moves while en is high.
  logic       prev_en  = 1'b0;
  logic [2:0] prev_sel = 3'd0;

  always @(negedge clk) begin
    if (en === 1'b1 && (!prev_en || sel !== prev_sel)) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_sel", {61'd0, sel}, {61'd0, e.sel});
        chk("sb_nib", {60'd0, nib}, {60'd0, e.nib});
        chk("sb_fd",  {63'd0, fd},  {63'd0, e.fd});
      end
    end else begin
      chk("fd_quiet", {63'd0, fd}, 64'd0);
    end
    prev_en  <= en;
    prev_sel <= sel;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] en_v, en_x;
    logic [5:0]  dw_v;
    logic [15:0] e0_v, s0_v, f0_v;
    int          bad, hi, n;

    rst_n = 1'b0; run = 1'b1; mask = 8'hFF; data = 32'h7654_3210;
    run0 = 1'b0; mask0 = 8'h00;
    wait_neg(2);
    chk("rst_sel", {61'd0, sel}, 64'd0);
    chk("rst_en",  {63'd0, en},  64'd0);
    chk("rst_nib", {60'd0, nib}, 64'd0);
    chk("rst_fd",  {63'd0, fd},  64'd0);

    // Two full frames of all eight digits, wrap flagged on each 7->0.
    push(3'd0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int d = 1; d < 8; d++) push(3'(d), 1'b0);
      push(3'd0, 1'b1);
    end
    rst_n = 1'b1;
    wait_neg(1);
    chk("release_en", {63'd0, en}, 64'd1);

    bad = 0;
    for (int i = 0; i < 48; i++) begin
      en_v[47-i] = en;
      en_x[47-i] = ((i % 6) < 4);
      if (sel !== 3'((i / 6) % 8)) bad++;
      wait_neg(1);
    end
    chk("frame_en_pattern", {16'd0, en_v}, {16'd0, en_x});
    chk("frame_sel_bad", 64'(bad), 64'd0);
    wait_neg(49);
    chk("drain_frames", 64'(sb.size()), 64'd0);

    // Sparse mask: 2,7 alternate, wrap only on 7->2.
    mask = 8'b1000_0100;
    push(3'd2, 1'b0); push(3'd7, 1'b0); push(3'd2, 1'b1);
    push(3'd7, 1'b0); push(3'd2, 1'b1);
    wait_neg(30);
    chk("drain_sparse", 64'(sb.size()), 64'd0);
    mask = 8'h00;
    wait_neg(6);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      hi += int'(en);
      wait_neg(1);
    end
    chk("empty_mask_en", 64'(hi), 64'd0);
    chk("empty_mask_sel", {61'd0, sel}, 64'd2);

    // Pause on digit 5 mid-dwell, then resume with a full dwell.
    mask = 8'hFF;
    push(3'd2, 1'b0); push(3'd3, 1'b0); push(3'd4, 1'b0); push(3'd5, 1'b0);
    wait_show(3'd5, 60, "reach_sel5");
    wait_neg(1);
    data = 32'hFFFF_FFFF;
    wait_neg(1);
    chk("nib_ignores_data", {60'd0, nib}, 64'd5);
    run = 1'b0;
    wait_neg(1);
    chk("pause_en",  {63'd0, en},  64'd0);
    chk("pause_sel", {61'd0, sel}, 64'd5);
    chk("pause_nib", {60'd0, nib}, 64'd5);
    data = 32'h7654_3210;
    wait_neg(2);
    chk("pause_hold_en", {63'd0, en}, 64'd0);
    push(3'd5, 1'b0); push(3'd6, 1'b0);
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_neg(1);
      dw_v[5-i] = en;
    end
    chk("resume_dwell", {58'd0, dw_v}, {58'd0, 6'b111100});

    // Reset in the blank gap after digit 6.
    wait_show(3'd6, 10, "reach_sel6");
    wait_neg(4);
    chk("blank_en", {63'd0, en}, 64'd0);
    rst_n = 1'b0;
    wait_neg(1);
    chk("mid_rst_sel", {61'd0, sel}, 64'd0);
    chk("mid_rst_en",  {63'd0, en},  64'd0);
    chk("mid_rst_nib", {60'd0, nib}, 64'd0);
    chk("mid_rst_fd",  {63'd0, fd},  64'd0);
    push(3'd0, 1'b0); push(3'd1, 1'b0);
    rst_n = 1'b1;
    wait_show(3'd1, 20, "restart_sel1");
    run = 1'b0;
    wait_neg(2);
    chk("drain_restart", 64'(sb.size()), 64'd0);

    // Gapless variant: en never drops, sel toggles every 4 cycles.
    mask0 = 8'h03;
    run0  = 1'b1;
    n = 0;
    do begin
      wait_neg(1);
      n++;
    end while (en0 !== 1'b1 && n < 5);
    chk("nogap_start", {63'd0, en0}, 64'd1);
    for (int i = 0; i < 16; i++) begin
      e0_v[15-i] = en0;
      s0_v[15-i] = (sel0 == 3'd1);
      f0_v[15-i] = fd0;
      wait_neg(1);
    end
    chk("nogap_en",  {48'd0, e0_v}, {48'd0, 16'hFFFF});
    chk("nogap_sel", {48'd0, s0_v}, {48'd0, 16'h0F0F});
    chk("nogap_fd",  {48'd0, f0_v}, {48'd0, 16'h0080});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
